tile_spawner: RTL and testbench

TILE_SPAWNER -- requirements
Module: tile_spawner

---
 rtl/tile_spawner_pkg.sv | 74 +++++++
 rtl/tile_spawner_memory_pattern.sv | 14 +
 rtl/tile_spawner.sv | 161 ++++++++++++++++
 tb/tb_tile_spawner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_spawner_pkg.sv
// Shared tetromino types, spawner FSM states and the shape ROM contents.
// Shape masks are 4x4, bit index y*4+x, y=0 is the top row.
package tetris;

   localparam int PT_X_W = 6;
   localparam int PT_Y_W = 7;

   typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;

   typedef struct packed {
      logic [PT_X_W-1:0] x_m;
      logic [PT_Y_W-1:0] y_m;
   } point_t;

   typedef struct packed {
      logic [15:0] mask_m;
      logic [1:0]  min_x_m;
      logic [1:0]  max_x_m;
      logic [1:0]  min_y_m;
      logic [1:0]  max_y_m;
   } shape_info_t;

   typedef enum logic [2:0] {eIDLE, eFetch, eCheck, eUpdate, eWaiting, eOver} spawn_state_e;

   // Each angle step rotates clockwise in the 4x4 box: (x,y) -> (3-y,x).
   function automatic shape_info_t shape_word(input logic [4:0] addr);
      shape_info_t s;
      logic [15:0] m;
      logic [15:0] t;
      logic        any;
      case (addr[4:2])
         eI:      m = 16'h00F0;
         eO:      m = 16'h0066;
         eT:      m = 16'h0072;
         eS:      m = 16'h0036;
         eZ:      m = 16'h0063;
         eJ:      m = 16'h0071;
         eL:      m = 16'h0074;
         default: m = 16'h0000;
      endcase
      for (int r = 0; r < 3; r++) begin
         if (r < int'(addr[1:0])) begin
            t = '0;
            for (int y = 0; y < 4; y++)
               for (int x = 0; x < 4; x++)
                  t[x*4 + 3 - y] = m[y*4 + x];
            m = t;
         end
      end
      s.mask_m  = m;
      s.min_x_m = 2'd3;
      s.max_x_m = 2'd0;
      s.min_y_m = 2'd3;
      s.max_y_m = 2'd0;
      any       = 1'b0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            if (m[y*4 + x]) begin
               any = 1'b1;
               if (2'(x) < s.min_x_m) s.min_x_m = 2'(x);
               if (2'(x) > s.max_x_m) s.max_x_m = 2'(x);
               if (2'(y) < s.min_y_m) s.min_y_m = 2'(y);
               if (2'(y) > s.max_y_m) s.max_y_m = 2'(y);
            end
         end
      end
      if (!any) begin
         s.min_x_m = 2'd0;
         s.min_y_m = 2'd0;
      end
      return s;
   endfunction

endpackage

// File: rtl/tile_spawner_memory_pattern.sv
// Combinational shape ROM addressed by {tile type, angle}.
module memory_pattern
   import tetris::*;
#(
   parameter int width_p = 24,
   parameter int depth_p = 32
) (
   input  logic [$clog2(depth_p)-1:0] i_addr,
   output logic [width_p-1:0]         o_data
);

   assign o_data = width_p'(shape_word(5'(i_addr)));

endmodule

// File: rtl/tile_spawner.sv
// Pending-tile queue plus the spawn sequencer: pop, place at the spawn point,
// ask for a collision check, then commit or declare game over.
module tile_spawner
   import tetris::*;
#(
   parameter int height_p      = 32,
   parameter int width_p       = 16,
   parameter int queue_depth_p = 4,
   parameter int spawn_x_p     = width_p/2 - 2
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  tile_type_e                         tile_type_i,
   input  logic [1:0]                         tile_angle_i,
   input  logic                               v_i,
   output logic                               ready_o,
   output tile_type_e                         preview_type_o,
   output logic                               preview_v_o,
   output logic [$clog2(queue_depth_p+1)-1:0] count_o,
   output logic                               chk_v_o,
   input  logic                               chk_done_i,
   input  logic                               chk_hit_i,
   output tile_type_e                         tile_type_o,
   output logic [1:0]                         tile_angle_o,
   output point_t                             pos_o,
   output logic                               v_o,
   input  logic                               cm_is_ready_i,
   output logic                               done_o,
   output logic                               game_over_o,
   input  logic                               restart_i
);

   localparam int CNT_W = $clog2(queue_depth_p+1);
   localparam int PTR_W = (queue_depth_p > 1) ? $clog2(queue_depth_p) : 1;
   localparam int Y_W   = $clog2(height_p) + 1;

   spawn_state_e      r_state, w_next;
   tile_type_e        r_q_type  [queue_depth_p];
   logic [1:0]        r_q_angle [queue_depth_p];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   tile_type_e        r_tile_type;
   logic [1:0]        r_tile_angle;
   point_t            r_pos;
   logic              w_push, w_pop, w_flush;
   logic [23:0]       w_rom;
   shape_info_t       w_shape;
   logic [Y_W-1:0]    w_spawn_y;
   logic [PT_Y_W-1:0] w_spawn_y_ext;
   logic              w_unused_shape;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(queue_depth_p-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign preview_v_o    = (r_count != '0);
   assign preview_type_o = preview_v_o ? r_q_type[r_rd_ptr] : eNon;
   assign count_o        = r_count;
   assign ready_o        = (r_count < CNT_W'(queue_depth_p)) && (r_state != eOver);
   assign w_push         = v_i && ready_o && (tile_type_i != eNon);
   assign w_flush        = (r_state == eOver) && restart_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < queue_depth_p; i++) begin
            r_q_type[i]  <= eNon;
            r_q_angle[i] <= '0;
         end
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_q_type[r_wr_ptr]  <= tile_type_i;
            r_q_angle[r_wr_ptr] <= tile_angle_i;
            r_wr_ptr            <= inc_ptr(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= inc_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= eIDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         eIDLE:    if (preview_v_o && cm_is_ready_i) w_next = eFetch;
         eFetch:   w_next = eCheck;
         eCheck:   if (chk_done_i) w_next = chk_hit_i ? eOver : eUpdate;
         eUpdate:  w_next = eWaiting;
         eWaiting: if (cm_is_ready_i) w_next = eIDLE;
         eOver:    if (restart_i) w_next = eIDLE;
         default:  w_next = eIDLE;
      endcase
   end

   always_comb begin
      w_pop       = 1'b0;
      chk_v_o     = 1'b0;
      v_o         = 1'b0;
      done_o      = 1'b0;
      game_over_o = 1'b0;
      case (r_state)
         eIDLE:    w_pop       = preview_v_o && cm_is_ready_i;
         eCheck:   chk_v_o     = 1'b1;
         eUpdate:  v_o         = 1'b1;
         eWaiting: done_o      = cm_is_ready_i;
         eOver:    game_over_o = 1'b1;
         default:  ;
      endcase
   end

   memory_pattern #(.width_p(24), .depth_p(32)) u_shape_rom (
      .i_addr ({r_tile_type, r_tile_angle}),
      .o_data (w_rom)
   );

   assign w_shape        = shape_info_t'(w_rom);
   assign w_unused_shape = ^{w_shape.mask_m, w_shape.min_x_m, w_shape.max_x_m, w_shape.min_y_m};

   // Spawn row sits fully above the board: -(max_y+1) in board-height arithmetic.
   assign w_spawn_y = ~Y_W'(w_shape.max_y_m);

   always_comb begin
      w_spawn_y_ext          = {PT_Y_W{w_spawn_y[Y_W-1]}};
      w_spawn_y_ext[Y_W-1:0] = w_spawn_y;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_tile_type  <= eNon;
         r_tile_angle <= '0;
         r_pos        <= '0;
      end else if (w_flush) begin
         r_tile_type  <= eNon;
      end else if (w_pop) begin
         r_tile_type  <= r_q_type[r_rd_ptr];
         r_tile_angle <= r_q_angle[r_rd_ptr];
      end else if (r_state == eFetch) begin
         r_pos.x_m    <= PT_X_W'(spawn_x_p);
         r_pos.y_m    <= w_spawn_y_ext;
      end
   end

   assign tile_type_o  = r_tile_type;
   assign tile_angle_o = r_tile_angle;
   assign pos_o        = r_pos;

endmodule

// File: tb/tb_tile_spawner.sv
// Scoreboarded bench for tile_spawner: queueing, spawn latency/position,
// collision stall, game over/restart and asynchronous reset.
module tb_tile_spawner;
   import tetris::*;

   logic       clk = 1'b0;
   logic       reset_n_i;
   tile_type_e tile_type_i;
   logic [1:0] tile_angle_i;
   logic       v_i, ready_o, preview_v_o;
   tile_type_e preview_type_o, tile_type_o;
   logic [2:0] count_o;
   logic       chk_v_o, chk_done_i, chk_hit_i;
   logic [1:0] tile_angle_o;
   point_t     pos_o;
   logic       v_o, cm_is_ready_i, done_o, game_over_o, restart_i;

   typedef struct {
      tile_type_e t;
      logic [1:0] a;
      logic [6:0] y;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_err = 0;
   int   n_vo = 0, n_done = 0;
   int   cyc = 0, last_push = 0;
   int   hit_mode = 0, chk_delay = 0, cwait = 0;

   tile_spawner #(.height_p(32), .width_p(16), .queue_depth_p(4)) dut (
      .clk_i(clk), .reset_n_i(reset_n_i),
      .tile_type_i(tile_type_i), .tile_angle_i(tile_angle_i), .v_i(v_i), .ready_o(ready_o),
      .preview_type_o(preview_type_o), .preview_v_o(preview_v_o), .count_o(count_o),
      .chk_v_o(chk_v_o), .chk_done_i(chk_done_i), .chk_hit_i(chk_hit_i),
      .tile_type_o(tile_type_o), .tile_angle_o(tile_angle_o), .pos_o(pos_o),
      .v_o(v_o), .cm_is_ready_i(cm_is_ready_i), .done_o(done_o),
      .game_over_o(game_over_o), .restart_i(restart_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Spawn row from base-shape extents; rotation k maps the row to
   // max y, max x, 3-min y, 3-min x.
   function automatic logic [6:0] exp_y(input tile_type_e t, input logic [1:0] a);
      int mnx, mxx, mny, mxy, my;
      case (t)
         eI:      begin mnx = 0; mxx = 3; mny = 1; mxy = 1; end
         eO:      begin mnx = 1; mxx = 2; mny = 0; mxy = 1; end
         default: begin mnx = 0; mxx = 2; mny = 0; mxy = 1; end
      endcase
      case (a)
         2'd0:    my = mxy;
         2'd1:    my = mxx;
         2'd2:    my = 3 - mny;
         default: my = 3 - mnx;
      endcase
      return 7'(-(my + 1));
   endfunction

   // Collision checker model: answers after chk_delay extra cycles.
   always @(negedge clk) begin
      if (chk_v_o) begin
         chk_done_i = (cwait == chk_delay);
         chk_hit_i  = chk_done_i && (hit_mode != 0);
         cwait++;
      end else begin
         chk_done_i = 1'b0;
         chk_hit_i  = 1'b0;
         cwait      = 0;
      end
   end

   always @(negedge clk) begin
      if (reset_n_i) begin
         if (v_o) begin
            n_vo++;
            if (sb.size() == 0) chk("sb_extra_vo", v_o, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("sp_type", tile_type_o, e.t);
               chk("sp_angle", tile_angle_o, e.a);
               chk("sp_x", pos_o.x_m, 6);
               chk("sp_y", pos_o.y_m, e.y);
            end
         end
         if (done_o) n_done++;
      end
   end

   task automatic push_tile(input tile_type_e t, input logic [1:0] a, input bit acc);
      @(posedge clk); #1;
      tile_type_i = t; tile_angle_i = a; v_i = 1'b1;
      if (acc) sb.push_back('{t, a, exp_y(t, a)});
      @(posedge clk); #1;
      v_i = 1'b0; tile_type_i = eNon;
      last_push = cyc;
   endtask

   task automatic wait_vo(input int target);
      for (int i = 0; i < 100 && n_vo < target; i++) begin @(negedge clk); #1; end
      chk("vo_count", n_vo, target);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 100 && n_done < target; i++) begin @(negedge clk); #1; end
      chk("done_count", n_done, target);
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_cnt"}, count_o, 0);
      chk({p, "_ready"}, ready_o, 1);
      chk({p, "_pv"}, preview_v_o, 0);
      chk({p, "_ptype"}, preview_type_o, eNon);
      chk({p, "_type"}, tile_type_o, eNon);
      chk({p, "_angle"}, tile_angle_o, 0);
      chk({p, "_pos"}, pos_o, 0);
      chk({p, "_v"}, v_o, 0);
      chk({p, "_chkv"}, chk_v_o, 0);
      chk({p, "_done"}, done_o, 0);
      chk({p, "_go"}, game_over_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int vo0, d0, n;
      reset_n_i = 1'b0; tile_type_i = eNon; tile_angle_i = '0; v_i = 1'b0;
      cm_is_ready_i = 1'b0; restart_i = 1'b0; chk_done_i = 1'b0; chk_hit_i = 1'b0;
      #12;
      check_reset_vals("rst");
      @(negedge clk); reset_n_i = 1'b1;

      // Single spawn: latency, position, done pulse
      cm_is_ready_i = 1'b1;
      push_tile(eT, 2'd1, 1);
      for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (v_o) break; end
      chk("lat_push_to_vo", cyc - last_push, 3);
      @(negedge clk); #1; chk("done_after_vo", done_o, 1);
      @(negedge clk); #1; chk("done_single", done_o, 0);

      // Fill to depth, eNon and overflow pushes dropped
      cm_is_ready_i = 1'b0;
      push_tile(eNon, 2'd0, 0);
      chk("enon_drop_cnt", count_o, 0);
      push_tile(eI, 2'd0, 1);
      push_tile(eO, 2'd1, 1);
      push_tile(eS, 2'd2, 1);
      push_tile(eZ, 2'd3, 1);
      chk("full_ready", ready_o, 0);
      chk("full_cnt", count_o, 4);
      chk("full_head", preview_type_o, eI);
      push_tile(eL, 2'd0, 0);
      chk("ovf_cnt", count_o, 4);

      // Push during pop on a full queue is rejected
      vo0 = n_vo; d0 = n_done;
      @(posedge clk); #1;
      cm_is_ready_i = 1'b1; tile_type_i = eJ; tile_angle_i = 2'd0; v_i = 1'b1;
      @(posedge clk); #1;
      v_i = 1'b0; tile_type_i = eNon;
      chk("pp_cnt", count_o, 3);
      chk("pp_head", preview_type_o, eO);
      wait_vo(vo0 + 4);
      wait_done(d0 + 4);
      chk("drain_cnt", count_o, 0);
      chk("drain_ptype", preview_type_o, eNon);

      // Restart outside eOver is ignored; collision hit leads to game over
      cm_is_ready_i = 1'b0;
      push_tile(eT, 2'd0, 0);
      push_tile(eO, 2'd2, 0);
      @(posedge clk); #1; restart_i = 1'b1;
      @(posedge clk); #1; restart_i = 1'b0;
      chk("rst_ign_cnt", count_o, 2);
      hit_mode = 1; vo0 = n_vo;
      cm_is_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (game_over_o) break; end
      chk("go_flag", game_over_o, 1);
      chk("go_ready", ready_o, 0);
      chk("go_type", tile_type_o, eT);
      push_tile(eI, 2'd0, 0);
      chk("go_cnt", count_o, 1);
      chk("go_no_vo", n_vo, vo0);
      @(posedge clk); #1; restart_i = 1'b1;
      @(posedge clk); #1; restart_i = 1'b0;
      chk("rs_cnt", count_o, 0);
      chk("rs_type", tile_type_o, eNon);
      chk("rs_go", game_over_o, 0);
      chk("rs_ready", ready_o, 1);
      hit_mode = 0;

      // Slow collision check
      chk_delay = 4; d0 = n_done;
      push_tile(eS, 2'd1, 1);
      for (int i = 0; i < 10; i++) begin @(negedge clk); #1; if (chk_v_o) break; end
      n = 0;
      while (chk_v_o && n < 50) begin n++; @(negedge clk); #1; end
      chk("chkv_len", n, 5);
      chk("vo_after_done", v_o, 1);
      wait_done(d0 + 1);
      chk_delay = 0;

      // Asynchronous reset while waiting on cell memory
      vo0 = n_vo;
      push_tile(eZ, 2'd1, 1);
      for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (v_o) break; end
      cm_is_ready_i = 1'b0;
      chk("wt_vo_seen", n_vo, vo0 + 1);
      d0 = n_done;
      @(posedge clk); #3;
      reset_n_i = 1'b0;
      #1;
      check_reset_vals("arst");
      cm_is_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_n_i = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("arst_no_done", n_done, d0);
      chk("arst_no_vo", n_vo, vo0 + 1);
      chk("sb_left", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
